// File: rtl/serial_bcd_alu_n.sv
// Serial BCD adder/subtractor for two DIGITS-digit operands with a sign/magnitude result.
// Latency: DIGITS+1 cycles from the close edge to the first valid bit, or 2*DIGITS+1 when A-B is negative.
// Backpressure: none; en/in are ignored while busy, and a frame is only accepted from IDLE.
//
// Ports:
//   clk    - single clock, all state on the rising edge
//   rst    - asynchronous active-low reset
//   en     - frame enable; in is sampled on each edge where en=1
//   in     - serial frame: op bit, then A digits, then B digits (MSB first)
//   result - serial result, MSB first: sign/carry nibble then DIGITS digits
//   valid  - high for the 4*(DIGITS+1) cycles that result carries data
//   busy   - high while calculating, negating or shifting out
//   err    - one-cycle pulse when a frame is rejected (bad length or bad digit)
module serial_bcd_alu_n #(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in,
  output logic result,
  output logic valid,
  output logic busy,
  output logic err
);

  localparam int F  = 1 + 8 * DIGITS;   // frame length in bits
  localparam int R  = 4 * (DIGITS + 1); // result length in bits
  localparam int NW = 4 * DIGITS;       // operand width
  localparam int CW = $clog2(F + 2);    // counter covers 0..F+1

  typedef enum logic [2:0] {IDLE, LOAD, CALC, NEG, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [F-1:0]    frame;
  logic [NW-1:0]   a_reg, b_reg, res;
  logic            op, carry;
  logic [R-1:0]    out_sr;
  logic            err_q;

  logic [NW-1:0]   frame_a, frame_b;
  logic            frame_ok;
  logic [3:0]      dig_x, dig_y, sum_dig;
  logic [4:0]      dig_sum, dig_adj;
  logic            sum_cy;
  logic [NW-1:0]   res_nxt;
  logic            last_digit;

  assign frame_a    = frame[2*NW-1:NW];
  assign frame_b    = frame[NW-1:0];
  assign last_digit = (cnt == CW'(DIGITS - 1));

  // A frame is good only with exactly F bits and every nibble a decimal digit.
  always_comb begin
    frame_ok = (cnt == CW'(F));
    for (int i = 0; i < DIGITS; i++) begin
      if (frame_a[4*i +: 4] > 4'd9 || frame_b[4*i +: 4] > 4'd9) frame_ok = 1'b0;
    end
  end

  // One shared decimal digit adder. CALC adds A_i to B_i (or to 9-B_i for subtract);
  // NEG adds 9-d_i to the ripple carry to ten's-complement the stored result.
  always_comb begin
    dig_x = a_reg[3:0];
    dig_y = op ? (4'd9 - b_reg[3:0]) : b_reg[3:0];
    if (state == NEG) begin
      dig_x = 4'd9 - res[3:0];
      dig_y = 4'd0;
    end
    dig_sum = 5'(dig_x) + 5'(dig_y) + 5'(carry);
    dig_adj = dig_sum - 5'd10;
    if (dig_sum > 5'd9) begin
      sum_dig = dig_adj[3:0];
      sum_cy  = 1'b1;
    end else begin
      sum_dig = dig_sum[3:0];
      sum_cy  = 1'b0;
    end
  end

  // res rotates one digit per cycle: the new digit enters at the top, so after
  // DIGITS cycles the least significant digit is back at the bottom.
  assign res_nxt = NW'({sum_dig, res} >> 4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: if (!en) state_nxt = frame_ok ? CALC : IDLE;
      CALC: begin
        busy = 1'b1;
        if (last_digit) state_nxt = (!op || sum_cy) ? SHIFT : NEG;
      end
      NEG: begin
        busy = 1'b1;
        if (last_digit) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        valid = 1'b1;
        if (cnt == CW'(R - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign result = valid & out_sr[R-1];
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      frame  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      op     <= 1'b0;
      carry  <= 1'b0;
      out_sr <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            frame <= {frame[F-2:0], in};
            cnt   <= CW'(1);
          end
        end
        LOAD: begin
          if (en) begin
            // Overrun bits are counted (saturating at F+1) but not stored.
            if (cnt < CW'(F))     frame <= {frame[F-2:0], in};
            if (cnt < CW'(F + 1)) cnt   <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            if (frame_ok) begin
              a_reg <= frame_a;
              b_reg <= frame_b;
              op    <= frame[F-1];
              carry <= frame[F-1]; // subtract starts with carry-in 1
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CALC: begin
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          res   <= res_nxt;
          carry <= sum_cy;
          cnt   <= cnt + CW'(1);
          if (last_digit) begin
            cnt <= '0;
            // Add: top nibble is the carry. Subtract with carry out: +|A-B|.
            // Subtract without carry out: negate next, seeding its +1.
            if (!op || sum_cy) out_sr <= {3'b000, ~op & sum_cy, res_nxt};
            else               carry  <= 1'b1;
          end
        end
        NEG: begin
          res   <= res_nxt;
          carry <= sum_cy;
          cnt   <= cnt + CW'(1);
          if (last_digit) begin
            cnt    <= '0;
            out_sr <= {4'b0001, res_nxt};
          end
        end
        SHIFT: begin
          out_sr <= out_sr << 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(R - 1)) cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bcd_alu_n.sv
// Bench for serial_bcd_alu_n: three instances (DIGITS = 4, 1, 8) share clock and reset.
// Each scenario task drives frames and compares against constants or an integer
// arithmetic reference model of the decimal add / signed subtract.
module tb_serial_bcd_alu_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en_v, in_v;
  wire  [2:0] result_v, valid_v, busy_v, err_v;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_bcd_alu_n #(.DIGITS(4)) u_d4 (.clk(clk), .rst(rst), .en(en_v[0]), .in(in_v[0]),
    .result(result_v[0]), .valid(valid_v[0]), .busy(busy_v[0]), .err(err_v[0]));
  serial_bcd_alu_n #(.DIGITS(1)) u_d1 (.clk(clk), .rst(rst), .en(en_v[1]), .in(in_v[1]),
    .result(result_v[1]), .valid(valid_v[1]), .busy(busy_v[1]), .err(err_v[1]));
  serial_bcd_alu_n #(.DIGITS(8)) u_d8 (.clk(clk), .rst(rst), .en(en_v[2]), .in(in_v[2]),
    .result(result_v[2]), .valid(valid_v[2]), .busy(busy_v[2]), .err(err_v[2]));

  // Directed cases: instance, op, A, B, expected result bits, latency, busy cycles.
  int          dsel [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2};
  bit          dop  [10] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
  logic [31:0] da   [10] = '{32'h1234, 32'h1234, 32'h0500, 32'h9999, 32'h0, 32'h0,
                             32'h3, 32'h3, 32'h12345678, 32'h00000500};
  logic [31:0] db   [10] = '{32'h8766, 32'h0500, 32'h1234, 32'h9999, 32'h0, 32'h0,
                             32'h8, 32'h8, 32'h87654322, 32'h00001234};
  logic [35:0] dexp [10] = '{36'h10000, 36'h00734, 36'h10734, 36'h19998, 36'h0, 36'h0,
                             36'h11, 36'h15, 36'h100000000, 36'h100000734};
  int          dlat [10] = '{5, 5, 9, 5, 5, 5, 2, 3, 9, 17};
  int          dbusy[10] = '{24, 24, 28, 24, 24, 24, 9, 10, 44, 52};

  function automatic int dg(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
  endfunction

  function automatic logic [127:0] mk_frame(input int d, input bit op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [127:0] f;
    f = 128'(op);
    for (int i = d - 1; i >= 0; i--) f = {f[123:0], a[4*i +: 4]};
    for (int i = d - 1; i >= 0; i--) f = {f[123:0], b[4*i +: 4]};
    return f;
  endfunction

  function automatic logic [31:0] rand_bcd(input int d);
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < d; i++) x[4*i +: 4] = 4'($urandom_range(9, 0));
    return x;
  endfunction

  function automatic longint bcd_val(input int d, input logic [31:0] x);
    longint v;
    v = 0;
    for (int i = d - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  // Reference: decimal sum (carry nibble) or sign/magnitude difference.
  task automatic model(input int d, input bit op, input longint a, input longint b,
                       output logic [35:0] eb, output int lat, output int bcnt);
    longint p10, m, top;
    p10 = 1;
    for (int i = 0; i < d; i++) p10 = p10 * 10;
    if (!op) begin
      top = (a + b) / p10; m = (a + b) % p10; lat = d + 1;
    end else if (a >= b) begin
      top = 0; m = a - b; lat = d + 1;
    end else begin
      top = 1; m = b - a; lat = 2 * d + 1;
    end
    eb = '0;
    for (int i = 0; i < d; i++) begin
      eb[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    eb[4*d +: 4] = 4'(top);
    bcnt = lat - 1 + 4 * (d + 1);
  endtask

  task automatic send_frame(input int sel, input logic [127:0] f, input int n, input bit skip_first);
    for (int i = 0; i < n; i++) begin
      if (!(i == 0 && skip_first)) @(negedge clk);
      en_v[sel] = 1'b1;
      in_v[sel] = f[n-1-i];
    end
    @(negedge clk);
    en_v[sel] = 1'b0;
    in_v[sel] = 1'b0;
  endtask

  // Watches the cycles after a close edge (cycle 1 is the first). mode 1: random en/in
  // while busy; mode 2: en held high with random in, returning in the first idle cycle.
  task automatic measure(input int sel, input int mode, input int win,
                         output int fv, output int nv, output int bc, output int fb,
                         output int ec, output int ef, output int leak,
                         output logic [35:0] got, output bit tmo);
    fv = -1; nv = 0; bc = 0; fb = -1; ec = 0; ef = -1; leak = 0; got = '0; tmo = 1'b1;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (valid_v[sel]) begin
        if (fv < 0) fv = k;
        nv++;
        got = {got[34:0], result_v[sel]};
      end else if (result_v[sel]) begin
        leak++;
      end
      if (busy_v[sel]) begin bc++; if (fb < 0) fb = k; end
      if (err_v[sel])  begin ec++; if (ef < 0) ef = k; end
      if (mode == 1) begin
        en_v[sel] = busy_v[sel] ? 1'($urandom) : 1'b0;
        in_v[sel] = 1'($urandom);
      end else if (mode == 2) begin
        en_v[sel] = 1'b1;
        in_v[sel] = 1'($urandom);
      end
      if (fv >= 0 && !valid_v[sel]) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; en_v = '0; in_v = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({result_v, valid_v, busy_v, err_v} !== 12'h0)
      begin fails++; $display("FAIL reset_outputs: got %h, want 000", {result_v, valid_v, busy_v, err_v}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int fv, nv, bc, fb, ec, ef, leak, s; logic [35:0] got; bit tmo;
    for (int i = 0; i < 10; i++) begin
      s = dsel[i];
      send_frame(s, mk_frame(dg(s), dop[i], da[i], db[i]), 1 + 8 * dg(s), 1'b0);
      measure(s, 0, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
      tests_run++; if (tmo !== 1'b0) begin fails++; $display("FAIL dir%0d timeout: no complete result", i); end
      tests_run++; if (got !== dexp[i]) begin fails++; $display("FAIL dir%0d result: got %h, want %h", i, got, dexp[i]); end
      tests_run++; if (fv !== dlat[i]) begin fails++; $display("FAIL dir%0d latency: got %0d, want %0d", i, fv, dlat[i]); end
      tests_run++; if (nv !== 4 * (dg(s) + 1)) begin fails++; $display("FAIL dir%0d valid_len: got %0d, want %0d", i, nv, 4 * (dg(s) + 1)); end
      tests_run++; if (bc !== dbusy[i]) begin fails++; $display("FAIL dir%0d busy_len: got %0d, want %0d", i, bc, dbusy[i]); end
      tests_run++; if (fb !== 1) begin fails++; $display("FAIL dir%0d busy_rise: got %0d, want 1", i, fb); end
      tests_run++; if (ec !== 0) begin fails++; $display("FAIL dir%0d err: got %0d pulses, want 0", i, ec); end
      tests_run++; if (leak !== 0) begin fails++; $display("FAIL dir%0d result_leak: got %0d, want 0", i, leak); end
    end
  endtask

  task automatic test_random;
    int fv, nv, bc, fb, ec, ef, leak, lat, bcnt, d; logic [35:0] got, eb; bit tmo, op;
    logic [31:0] a, b;
    for (int s = 0; s < 3; s++) begin
      d = dg(s);
      for (int n = 0; n < 5; n++) begin
        op = 1'($urandom); a = rand_bcd(d); b = rand_bcd(d);
        model(d, op, bcd_val(d, a), bcd_val(d, b), eb, lat, bcnt);
        send_frame(s, mk_frame(d, op, a, b), 1 + 8 * d, 1'b0);
        measure(s, 0, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
        tests_run++; if (got !== eb) begin fails++; $display("FAIL rand d%0d op%0d %h,%h result: got %h, want %h", d, op, a, b, got, eb); end
        tests_run++; if (fv !== lat) begin fails++; $display("FAIL rand d%0d latency: got %0d, want %0d", d, fv, lat); end
        tests_run++; if (nv !== 4 * (d + 1)) begin fails++; $display("FAIL rand d%0d valid_len: got %0d, want %0d", d, nv, 4 * (d + 1)); end
        tests_run++; if (bc !== bcnt) begin fails++; $display("FAIL rand d%0d busy_len: got %0d, want %0d", d, bc, bcnt); end
        tests_run++; if (leak !== 0 || ec !== 0) begin fails++; $display("FAIL rand d%0d leak/err: got %0d/%0d, want 0/0", d, leak, ec); end
      end
    end
  endtask

  task automatic test_en_noise;
    int fv, nv, bc, fb, ec, ef, leak, lat, bcnt, d; logic [35:0] got, eb; bit tmo, op;
    logic [31:0] a, b;
    for (int s = 0; s < 3; s++) begin
      d = dg(s);
      for (int n = 0; n < 2; n++) begin
        op = 1'($urandom); a = rand_bcd(d); b = rand_bcd(d);
        model(d, op, bcd_val(d, a), bcd_val(d, b), eb, lat, bcnt);
        send_frame(s, mk_frame(d, op, a, b), 1 + 8 * d, 1'b0);
        measure(s, 1, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
        tests_run++; if (got !== eb) begin fails++; $display("FAIL noise d%0d result: got %h, want %h", d, got, eb); end
        tests_run++; if (fv !== lat) begin fails++; $display("FAIL noise d%0d latency: got %0d, want %0d", d, fv, lat); end
        tests_run++; if (nv !== 4 * (d + 1) || ec !== 0) begin fails++; $display("FAIL noise d%0d valid_len/err: got %0d/%0d, want %0d/0", d, nv, ec, 4 * (d + 1)); end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int fv, nv, bc, fb, ec, ef, leak, lat, bcnt, d; logic [35:0] got, eb; bit tmo, op;
    logic [31:0] a, b;
    for (int s = 0; s < 3; s++) begin
      d = dg(s);
      op = 1'($urandom); a = rand_bcd(d); b = rand_bcd(d);
      model(d, op, bcd_val(d, a), bcd_val(d, b), eb, lat, bcnt);
      send_frame(s, mk_frame(d, op, a, b), 1 + 8 * d, 1'b0);
      measure(s, 2, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
      tests_run++; if (got !== eb || nv !== 4 * (d + 1)) begin fails++; $display("FAIL b2b d%0d first: got %h/%0d, want %h/%0d", d, got, nv, eb, 4 * (d + 1)); end
      // en is still high here: the first bit of the next frame goes in this idle cycle.
      op = 1'($urandom); a = rand_bcd(d); b = rand_bcd(d);
      model(d, op, bcd_val(d, a), bcd_val(d, b), eb, lat, bcnt);
      send_frame(s, mk_frame(d, op, a, b), 1 + 8 * d, 1'b1);
      measure(s, 0, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
      tests_run++; if (got !== eb) begin fails++; $display("FAIL b2b d%0d second result: got %h, want %h", d, got, eb); end
      tests_run++; if (fv !== lat || nv !== 4 * (d + 1)) begin fails++; $display("FAIL b2b d%0d second timing: got %0d/%0d, want %0d/%0d", d, fv, nv, lat, 4 * (d + 1)); end
    end
  endtask

  task automatic test_errors;
    int fv, nv, bc, fb, ec, ef, leak, s, n; logic [35:0] got; bit tmo;
    logic [127:0] f, good;
    for (int c = 0; c < 6; c++) begin
      s = (c == 5) ? 1 : 0;
      good = mk_frame(dg(s), 1'b0, 32'h0, 32'h1);
      n = 1 + 8 * dg(s);
      case (c)
        0: f = mk_frame(4, 1'b0, 32'h12A4, 32'h0001);
        1: f = mk_frame(4, 1'b1, 32'h0001, 32'h000F);
        2: begin f = good >> 1; n = n - 1; end
        3: begin f = (good << 1) | 128'h1; n = n + 1; end
        4: begin f = good << 5; n = n + 5; end
        default: f = mk_frame(1, 1'b0, 32'hB, 32'h1);
      endcase
      send_frame(s, f, n, 1'b0);
      measure(s, 0, 40, fv, nv, bc, fb, ec, ef, leak, got, tmo);
      tests_run++; if (ec !== 1) begin fails++; $display("FAIL err%0d pulse_count: got %0d, want 1", c, ec); end
      tests_run++; if (ef !== 1) begin fails++; $display("FAIL err%0d pulse_cycle: got %0d, want 1", c, ef); end
      tests_run++; if (fv !== -1 || bc !== 0) begin fails++; $display("FAIL err%0d output: valid_at %0d busy %0d, want -1/0", c, fv, bc); end
      send_frame(s, good, 1 + 8 * dg(s), 1'b0);
      measure(s, 0, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
      tests_run++; if (got !== 36'h1) begin fails++; $display("FAIL err%0d recovery result: got %h, want 1", c, got); end
      tests_run++; if (fv !== dg(s) + 1) begin fails++; $display("FAIL err%0d recovery latency: got %0d, want %0d", c, fv, dg(s) + 1); end
    end
  endtask

  task automatic test_reset_mid_shift;
    int nvs, leakv, fv, nv, bc, fb, ec, ef, leak; bit hit, tmo; logic [35:0] got;
    send_frame(0, mk_frame(4, 1'b0, 32'h1234, 32'h8766), 33, 1'b0);
    nvs = 0; hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (valid_v[0]) begin
        if (nvs == 7) begin rst = 1'b0; #1; hit = 1'b1; end
        nvs++;
      end
    end
    tests_run++; if (hit !== 1'b1) begin fails++; $display("FAIL rst_mid reach_bit7: got %0d, want 1", hit); end
    tests_run++;
    if ({valid_v[0], result_v[0], busy_v[0]} !== 3'b000)
      begin fails++; $display("FAIL rst_mid outputs: got %b, want 000", {valid_v[0], result_v[0], busy_v[0]}); end
    @(negedge clk);
    rst = 1'b1;
    leakv = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_v[0] || result_v[0] || busy_v[0]) leakv++;
    end
    tests_run++; if (leakv !== 0) begin fails++; $display("FAIL rst_mid residual: got %0d cycles, want 0", leakv); end
    send_frame(0, mk_frame(4, 1'b0, 32'h1234, 32'h8766), 33, 1'b0);
    measure(0, 0, 200, fv, nv, bc, fb, ec, ef, leak, got, tmo);
    tests_run++; if (got !== 36'h10000 || fv !== 5) begin fails++; $display("FAIL rst_mid recovery: got %h at %0d, want 10000 at 5", got, fv); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_en_noise();
    test_back_to_back();
    test_errors();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
